// File: rtl/hc148_prio_irq.sv
// Clocked, parametrised 74HC148-style priority encoder with edge-latched pending requests.
// Optional macro HC148_PRIO_IRQ_MASK_EN adds the IrqMask port to hide pending bits from the search.
module hc148_prio_irq #(
    parameter int WIDTH = 8,
    parameter bit LATCH = 1'b1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [WIDTH-1:0]           DataIn,
    input  logic                       EI,
    input  logic                       Ack,
`ifdef HC148_PRIO_IRQ_MASK_EN
    input  logic [WIDTH-1:0]           IrqMask,
`endif
    output logic [$clog2(WIDTH)-1:0]   Dataout,
    output logic                       GS,
    output logic                       EO
);
    localparam int OW = $clog2(WIDTH);

    logic [WIDTH-1:0] s1_q, s2_q, s3_q;
    logic [WIDTH-1:0] s1_d, s2_d, s3_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] clr, eff, mask;
    logic [OW-1:0]    dout_q, dout_d, idx;
    logic             gs_q, gs_d, eo_q, eo_d;
    logic             ack_ok;

`ifdef HC148_PRIO_IRQ_MASK_EN
    assign mask = IrqMask;
`else
    assign mask = '0;
`endif

    always_comb begin
        s1_d = ~DataIn;
        s2_d = s1_q;
        s3_d = s2_q;

        // Search runs on the registered pending set; later indices overwrite earlier ones.
        eff    = pend_q & ~mask;
        dout_d = '1;
        gs_d   = 1'b1;
        eo_d   = 1'b1;
        if (!EI) begin
            eo_d = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (eff[i]) begin
                    dout_d = ~OW'(i);
                    gs_d   = 1'b0;
                    eo_d   = 1'b1;
                end
            end
        end

        // Ack only retires what the controller is actually being shown right now.
        idx    = ~dout_q;
        ack_ok = LATCH && Ack && !gs_q && !EI;
        clr    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (idx == OW'(i) && !mask[i])
                clr[i] = ack_ok;
        end

        // A fresh edge OR-ed in after the clear keeps a bit alive if both hit together.
        if (LATCH)
            pend_d = (pend_q & ~clr) | (s2_q & ~s3_q);
        else
            pend_d = s2_q;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            pend_q <= '0;
            dout_q <= '1;
            gs_q   <= 1'b1;
            eo_q   <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            pend_q <= pend_d;
            dout_q <= dout_d;
            gs_q   <= gs_d;
            eo_q   <= eo_d;
        end
    end

    assign Dataout = dout_q;
    assign GS      = gs_q;
    assign EO      = eo_q;
endmodule

// File: tb/tb_hc148_prio_irq.sv
// Bench for hc148_prio_irq: WIDTH=8/LATCH=1 and WIDTH=10/LATCH=0 instances against a history-window model.
module tb_hc148_prio_irq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ei, ack;
    logic [7:0] di_a, mk_a;
    logic [9:0] di_b, mk_b;
    logic [2:0] do_a;
    logic [3:0] do_b;
    logic       gs_a, eo_a, gs_b, eo_b;

    int total = 0;
    int bad   = 0;

    hc148_prio_irq #(.WIDTH(8), .LATCH(1'b1)) u_a (
        .Clk(clk), .Rst(rst), .DataIn(di_a), .EI(ei), .Ack(ack),
`ifdef HC148_PRIO_IRQ_MASK_EN
        .IrqMask(mk_a),
`endif
        .Dataout(do_a), .GS(gs_a), .EO(eo_a));

    hc148_prio_irq #(.WIDTH(10), .LATCH(1'b0)) u_b (
        .Clk(clk), .Rst(rst), .DataIn(di_b), .EI(ei), .Ack(ack),
`ifdef HC148_PRIO_IRQ_MASK_EN
        .IrqMask(mk_b),
`endif
        .Dataout(do_b), .GS(gs_b), .EO(eo_b));

    // Reference: hist[k][n] = active-high requests sampled n+1 edges ago (zero after reset).
    logic [15:0] hist [2][3];
    logic [15:0] pend [2];
    int          e_do [2];
    int          e_gs [2];
    int          e_eo [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic mstep(input int k, input int w, input bit latch,
                         input logic [15:0] req, input logic [15:0] msk);
        logic [15:0] eff, rise, clr;
        int ow, hi, idx, ones;
        ow   = $clog2(w);
        ones = (1 << ow) - 1;
        if (rst) begin
            pend[k] = '0;
            for (int n = 0; n < 3; n++) hist[k][n] = '0;
            e_do[k] = ones; e_gs[k] = 1; e_eo[k] = 1;
            return;
        end
        clr = '0;
        if (latch && ack && e_gs[k] == 0 && !ei) begin
            idx = (~e_do[k]) & ones;
            if (!msk[idx]) clr[idx] = 1'b1;
        end
        eff = pend[k] & ~msk;
        hi  = -1;
        for (int i = 0; i < w; i++) if (eff[i]) hi = i;
        if (ei)          begin e_do[k] = ones;          e_gs[k] = 1; e_eo[k] = 1; end
        else if (hi < 0) begin e_do[k] = ones;          e_gs[k] = 1; e_eo[k] = 0; end
        else             begin e_do[k] = (~hi) & ones;  e_gs[k] = 0; e_eo[k] = 1; end
        rise    = hist[k][1] & ~hist[k][2];
        pend[k] = latch ? ((pend[k] & ~clr) | rise) : hist[k][1];
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = req;
    endtask

    always @(posedge clk) begin
        logic [15:0] ma, mb;
`ifdef HC148_PRIO_IRQ_MASK_EN
        ma = {8'h00, mk_a};
        mb = {6'h00, mk_b};
`else
        ma = '0;
        mb = '0;
`endif
        mstep(0, 8,  1'b1, {8'h00, ~di_a}, ma);
        mstep(1, 10, 1'b0, {6'h00, ~di_b}, mb);
    end

    task automatic cyc();
        @(negedge clk);
        chk("a_do", do_a, e_do[0]); chk("a_gs", gs_a, e_gs[0]); chk("a_eo", eo_a, e_eo[0]);
        chk("b_do", do_b, e_do[1]); chk("b_gs", gs_b, e_gs[1]); chk("b_eo", eo_b, e_eo[1]);
    endtask

    task automatic ack_pulse();
        ack = 1'b1; cyc();
        ack = 1'b0; cyc();
    endtask

    initial begin
        rst = 1'b1; ei = 1'b0; ack = 1'b0;
        di_a = '1; di_b = '1; mk_a = '0; mk_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_do", do_a, 3'b111); chk("rst_gs", gs_a, 1); chk("rst_eo", eo_a, 1);
        rst = 1'b0;
        cyc();
        chk("rel_eo", eo_a, 0);

        // single pulse on bit 2, held until Ack
        di_a[2] = 1'b0; cyc(); di_a[2] = 1'b1;
        repeat (3) cyc();
        chk("p2_do", do_a, 3'b101); chk("p2_gs", gs_a, 0); chk("p2_eo", eo_a, 1);
        repeat (2) cyc();
        chk("p2_hold", do_a, 3'b101);
        ack_pulse();
        chk("p2_clr_do", do_a, 3'b111); chk("p2_clr_eo", eo_a, 0);

        // bits 7, 5, 1 together, retired in priority order
        di_a = 8'b0101_1101; cyc(); di_a = '1;
        repeat (3) cyc();
        chk("m_7", do_a, 3'b000);
        ack_pulse(); chk("m_5", do_a, 3'b010);
        ack_pulse(); chk("m_1", do_a, 3'b110);
        ack_pulse(); chk("m_idle", gs_a, 1);

        // Ack and a fresh bit-7 edge land on the same edge
        di_a[7] = 1'b0; cyc(); di_a[7] = 1'b1;
        repeat (3) cyc();
        di_a[7] = 1'b0; cyc(); di_a[7] = 1'b1; cyc();
        ack = 1'b1; cyc(); ack = 1'b0;
        repeat (2) cyc();
        chk("sim_do", do_a, 3'b000); chk("sim_gs", gs_a, 0);
        ack_pulse(); ack_pulse();
        chk("sim_idle", gs_a, 1);

        // capture continues while EI is high
        ei = 1'b1; di_a[4] = 1'b0; cyc(); di_a[4] = 1'b1;
        repeat (3) cyc();
        chk("ei_do", do_a, 3'b111); chk("ei_gs", gs_a, 1); chk("ei_eo", eo_a, 1);
        ack_pulse();
        ei = 1'b0; cyc();
        chk("ei_back_do", do_a, 3'b011); chk("ei_back_gs", gs_a, 0);
        ack_pulse();

        // level mode, non-power-of-two width
        di_b[9] = 1'b0; repeat (4) cyc();
        chk("b9_do", do_b, 4'b0110); chk("b9_gs", gs_b, 0);
        ack_pulse();
        chk("b9_ack", do_b, 4'b0110);
        di_b[9] = 1'b1; repeat (4) cyc();
        chk("b9_idle_do", do_b, 4'b1111); chk("b9_idle_eo", eo_b, 0);

`ifdef HC148_PRIO_IRQ_MASK_EN
        di_b[9] = 1'b0; di_b[3] = 1'b0; mk_b[9] = 1'b1; repeat (4) cyc();
        chk("mk_b_do", do_b, 4'b1100);
        mk_b = '0; cyc();
        chk("mk_b_un", do_b, 4'b0110);
        di_b = '1; repeat (4) cyc();
`endif

        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 8; i++)  di_a[i] = ($urandom_range(0, 5) != 0);
            for (int i = 0; i < 10; i++) di_b[i] = ($urandom_range(0, 5) != 0);
            ei  = ($urandom_range(0, 7) == 0);
            ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
`ifdef HC148_PRIO_IRQ_MASK_EN
            for (int i = 0; i < 8; i++)  mk_a[i] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 10; i++) mk_b[i] = ($urandom_range(0, 3) == 0);
`endif
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
